seq_player: RTL



---
 rtl/seq_pkg.sv | 33 +++
 rtl/seq_lfsr.sv | 62 ++++++
 rtl/seq_player.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence player:
//   - state_t     : playback FSM states
//   - LFSR_W      : LFSR width
//   - LFSR_RESET  : LFSR / seed register reset value (also replaces a zero seed)
//   - lfsr_next() : 8-bit Fibonacci LFSR step
//   - onehot_dec(): symbol index -> one-hot (up to OH_MAX colours)
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int                LFSR_W     = 8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;
  localparam int                OH_MAX     = 8;

  // Taps 8,6,5,4: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Symbol s drives bit s. Callers slice the result down to their colour count.
  function automatic logic [OH_MAX-1:0] onehot_dec(input logic [2:0] sym);
    return 8'b0000_0001 << sym;
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// -----------------------------------------------------------------------------
// seq_lfsr
// Seed register plus 8-bit LFSR. The seed register is written on i_seed_we
// (a zero seed is replaced by LFSR_RESET so the LFSR can never lock up).
// i_load copies the seed register into the LFSR, i_step advances it.
// o_sym_nxt is the low symbol field of the value the LFSR will hold after the
// current edge, so the owner can register the matching one-hot outputs in the
// same cycle the LFSR changes.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_seed      : seed value
//   i_seed_we   : write seed register
//   i_load      : LFSR <= seed register (has priority over i_step)
//   i_step      : LFSR <= lfsr_next(LFSR)
//   o_sym_nxt   : next symbol index
// -----------------------------------------------------------------------------
module seq_lfsr
  import seq_pkg::*;
#(
  parameter int SYM_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_seed,
  input  logic              i_seed_we,
  input  logic              i_load,
  input  logic              i_step,
  output logic [SYM_W-1:0]  o_sym_nxt
);

  logic [LFSR_W-1:0] r_seed;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_d;

  // Next LFSR value: reload from seed, step, or hold.
  always_comb begin
    w_lfsr_d = r_lfsr;
    if (i_load) begin
      w_lfsr_d = r_seed;
    end else if (i_step) begin
      w_lfsr_d = lfsr_next(r_lfsr);
    end else begin
      w_lfsr_d = r_lfsr;
    end
  end

  // Seed and LFSR registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seed <= LFSR_RESET;
      r_lfsr <= LFSR_RESET;
    end else begin
      if (i_seed_we) begin
        r_seed <= (i_seed == 8'h00) ? LFSR_RESET : i_seed;
      end
      r_lfsr <= w_lfsr_d;
    end
  end

  assign o_sym_nxt = w_lfsr_d[SYM_W-1:0];

endmodule

// File: rtl/seq_player.sv
// -----------------------------------------------------------------------------
// seq_player
// Plays the first `length` symbols (clamped to DEPTH) of a pseudo-random colour
// sequence derived from a loadable seed. Each symbol is driven one-hot on saida
// for ON_CYCLES cycles followed by OFF_CYCLES blank cycles. The same seed always
// yields the same prefix.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   seed       : LFSR seed, latched by load_seed while idle
//   load_seed  : store seed (ignored unless idle)
//   length     : symbols to play, latched at start
//   start      : one-cycle start pulse (ignored unless idle)
//   saida      : one-hot symbol during ON, zero otherwise
//   expected   : one-hot symbol at the current index (held through OFF/DONE)
//   index      : position of the symbol being played
//   busy       : high during ON and OFF
//   done       : one-cycle pulse after the last OFF phase
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_player
  import seq_pkg::*;
#(
  parameter int NCOLORS    = 4,
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 seed,
  input  logic                       load_seed,
  input  logic [$clog2(DEPTH+1)-1:0] length,
  input  logic                       start,
  output logic [NCOLORS-1:0]         saida,
  output logic [NCOLORS-1:0]         expected,
  output logic [$clog2(DEPTH)-1:0]   index,
  output logic                       busy,
  output logic                       done
);

  localparam int SYM_W   = $clog2(NCOLORS);
  localparam int LEN_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [IDX_W-1:0]   r_index;
  logic [IDX_W-1:0]   w_index_nxt;
  logic [NCOLORS-1:0] r_saida;
  logic [NCOLORS-1:0] w_saida_nxt;
  logic [NCOLORS-1:0] r_expected;
  logic [NCOLORS-1:0] w_expected_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;

  logic               w_load;
  logic               w_step;
  logic               w_seed_we;
  logic [SYM_W-1:0]   w_sym_nxt;
  logic [OH_MAX-1:0]  w_sym_oh8;
  logic [NCOLORS-1:0] w_sym_oh;
  logic               w_unused_oh_bits;
  logic [LEN_W-1:0]   w_len_clamp;
  logic               w_on_end;
  logic               w_off_end;
  logic               w_last;

  assign w_seed_we   = load_seed && (r_state == IDLE);
  assign w_len_clamp = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
  assign w_on_end    = (r_cnt == CNT_W'(ON_CYCLES - 1));
  assign w_off_end   = (r_cnt == CNT_W'(OFF_CYCLES - 1));
  // Compare index+1 against the latched length to avoid underflow at length 0.
  assign w_last      = ((LEN_W'(r_index) + LEN_W'(1'b1)) == r_len);

  seq_lfsr #(
    .SYM_W (SYM_W)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .i_seed    (seed),
    .i_seed_we (w_seed_we),
    .i_load    (w_load),
    .i_step    (w_step),
    .o_sym_nxt (w_sym_nxt)
  );

  assign w_sym_oh8        = onehot_dec(3'(w_sym_nxt));
  assign w_sym_oh         = w_sym_oh8[NCOLORS-1:0];
  assign w_unused_oh_bits = ^w_sym_oh8;

  // Next-state logic: phase timing, index advance, LFSR load/step requests.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_index_nxt = r_index;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_len_clamp != {LEN_W{1'b0}}) begin
            w_state_nxt = ON;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_len_nxt   = w_len_clamp;
            w_index_nxt = {IDX_W{1'b0}};
            w_load      = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ON: begin
        if (w_on_end) begin
          w_state_nxt = OFF;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
        end
      end
      OFF: begin
        if (w_off_end) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ON;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_index_nxt = r_index + IDX_W'(1'b1);
            w_step      = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output next values, aligned with the next state so outputs stay registered.
  always_comb begin
    w_busy_nxt     = (w_state_nxt == ON) || (w_state_nxt == OFF);
    w_done_nxt     = (w_state_nxt == DONE);
    w_saida_nxt    = {NCOLORS{1'b0}};
    w_expected_nxt = r_expected;
    if (w_state_nxt == ON) begin
      w_saida_nxt = w_sym_oh;
    end else begin
      w_saida_nxt = {NCOLORS{1'b0}};
    end
    if (w_load || w_step) begin
      w_expected_nxt = w_sym_oh;
    end else begin
      w_expected_nxt = r_expected;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_index    <= {IDX_W{1'b0}};
      r_saida    <= {NCOLORS{1'b0}};
      r_expected <= {NCOLORS{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_index    <= w_index_nxt;
      r_saida    <= w_saida_nxt;
      r_expected <= w_expected_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign saida    = r_saida;
  assign expected = r_expected;
  assign index    = r_index;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
